// File: rtl/spi_master_seq_pkg.sv
// Shared definitions for the SPI memory host sequencer: FSM states and frame layout.
package spi_defs;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD,
        DONE
    } stateT;

    localparam int unsigned DEF_ADDR_W = 7;
    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned FRAME_BITS = DEF_ADDR_W + 1 + DEF_DATA_W;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/spi_master_seq_sclk_gen.sv
// sclk half-period divider: tick every CLK_DIV clk cycles plus a half-period index.
module spi_sclk_gen #(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned HALF_N  = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      en,
    input  logic                      clr,
    input  logic                      halfEn,
    output logic                      tick,
    output logic [$clog2(HALF_N)-1:0] halfIdx
);

    localparam int unsigned CntW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int unsigned HalfW = $clog2(HALF_N);

    logic [CntW-1:0] cnt;

    assign tick = en && (cnt == CntW'(CLK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            halfIdx <= '0;
        end else if (clr) begin
            cnt     <= '0;
            halfIdx <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
            if (tick && halfEn)
                halfIdx <= (halfIdx == HalfW'(HALF_N - 1)) ? '0 : halfIdx + 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_seq.sv
// Host-side SPI sequencer: one {addr, rw, data} frame per accepted request,
// miso captured during the data phase and returned with a one-cycle response.
module spi_master_seq
    import spi_defs::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned ADDR_W  = 7,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              sclk,
    output logic              cs_n,
    output logic              mosi,
    input  logic              miso
);

    localparam int unsigned FrameBits = ADDR_W + 1 + DATA_W;
    localparam int unsigned HalfN     = 2 * FrameBits;
    localparam int unsigned HalfW     = $clog2(HalfN);
    // first low half-period whose ending tick is rising edge ADDR_W+2 (first data bit)
    localparam int unsigned RxStart   = 2 * ADDR_W + 1;

    stateT                state;
    logic [FrameBits-1:0] reqFrame;
    logic [FrameBits-1:0] txReg;
    logic [DATA_W-1:0]    rxReg;
    logic                 rwReg;
    logic                 divEn;
    logic                 tick;
    logic [HalfW-1:0]     halfIdx;

    assign reqFrame  = {req_addr, req_rw, (req_rw == RW_READ) ? {DATA_W{1'b0}} : req_wdata};
    assign req_ready = (state == IDLE) && !reset;
    assign divEn     = (state == SETUP) || (state == SHIFT) || (state == HOLD);

    spi_sclk_gen #(
        .CLK_DIV(CLK_DIV),
        .HALF_N (HalfN)
    ) uSclkGen (
        .clk    (clk),
        .rst    (reset),
        .en     (divEn),
        .clr    (!divEn),
        .halfEn (state == SHIFT),
        .tick   (tick),
        .halfIdx(halfIdx)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            txReg     <= '0;
            rxReg     <= '0;
            rwReg     <= RW_WRITE;
            sclk      <= 1'b0;
            cs_n      <= 1'b1;
            mosi      <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        // txReg holds the bits still to send after the one on mosi
                        mosi  <= reqFrame[FrameBits-1];
                        txReg <= {reqFrame[FrameBits-2:0], 1'b0};
                        rwReg <= req_rw;
                        cs_n  <= 1'b0;
                        sclk  <= 1'b0;
                        busy  <= 1'b1;
                        state <= SETUP;
                    end
                end
                SETUP: begin
                    if (tick) begin
                        sclk  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        if (!halfIdx[0]) begin
                            sclk  <= 1'b0;
                            mosi  <= txReg[FrameBits-1];
                            txReg <= {txReg[FrameBits-2:0], 1'b0};
                        end else if (halfIdx == HalfW'(HalfN - 1)) begin
                            state <= HOLD;
                        end else begin
                            sclk <= 1'b1;
                            if (halfIdx >= HalfW'(RxStart))
                                rxReg <= {rxReg[DATA_W-2:0], miso};
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        cs_n      <= 1'b1;
                        mosi      <= 1'b0;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= (rwReg == RW_WRITE) ? {DATA_W{1'b0}} : rxReg;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/spi_master_seq.md
Name: spi_master_seq

Overview:
- Host-side sequencer for the SPI memory slave (7-bit address, R/W bit, 8-bit data frame).
- Accepts one read or write request through a valid/ready handshake and generates sclk, cs_n and mosi for that request.
- Captures miso during the data phase and returns a one-cycle response.
- Used by the lab top level and by benches to drive the SPI memory without hand-written sclk waveforms.

Parameters:
- CLK_DIV, 4, system clk cycles per sclk half-period; legal range ≥2.
- ADDR_W, 7, address bits per frame.
- DATA_W, 8, data bits per frame.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_rw  input  1  1=read, 0=write.
- req_addr  input  ADDR_W  memory address.
- req_wdata  input  DATA_W  write data; ignored for reads.
- rsp_valid  output  1  one-cycle pulse when the frame completes.
- rsp_rdata  output  DATA_W  read data; 0x00 for writes; valid only with rsp_valid.
- busy  output  1  high from accept until the rsp_valid cycle inclusive.
- sclk  output  1  SPI clock; idles low.
- cs_n  output  1  chip select, active-low.
- mosi  output  1  serial out, MSB first.
- miso  input  1  serial in, from the slave.

Behaviour:
- Reset values (asynchronous on reset high): state IDLE; sclk=0, cs_n=1, mosi=0, rsp_valid=0, rsp_rdata=0, busy=0, req_ready=0 while reset is high.
- req_ready = (state==IDLE). It is 1 in the first clk after reset deasserts.
- Accept occurs when req_valid && req_ready at posedge T. The block latches the frame as {req_addr, req_rw, req_wdata} (16 bits, MSB first). For reads the data field is sent as zeros.
- A tick fires every CLK_DIV clk cycles, counted from the first cycle of SETUP. The divider is held cleared in IDLE and DONE.
- States and transitions:
  - IDLE: wait for accept, then go to SETUP.
  - SETUP: lasts 1 half-period. cs_n=0, sclk=0, mosi=frame[15]. On tick go to SHIFT.
  - SHIFT: lasts 32 half-periods.
    - Odd half-periods: sclk=1. On entering a high phase, sample miso; rising edges 9..16 shift miso into rx, MSB first.
    - Even half-periods: sclk=0. On entering a low phase, advance mosi to the next frame bit.
    - After the 32nd half-period sclk is low; go to HOLD.
  - HOLD: lasts 1 half-period. cs_n stays 0, sclk=0. On tick go to DONE.
  - DONE: lasts 1 clk. cs_n=1, mosi=0, rsp_valid=1, rsp_rdata = rx for reads or 0x00 for writes. Then go to IDLE.
- Latency: cs_n falls at T+1; rsp_valid is high in cycle T+1+34*CLK_DIV. Minimum cs_n-high gap between frames is 2 clk (DONE plus the IDLE accept cycle).
- Exactly 16 sclk rising edges occur per frame, and mosi is stable for the whole sclk-high phase.
- req_valid while busy: not accepted. Inputs are sampled only at accept, so later changes to req_* have no effect on the frame in flight.
- Reset mid-frame: immediate cs_n=1, sclk=0, no rsp_valid; the frame is lost and the slave is resynchronised by cs_n high.
- rsp_rdata holds its value until the next DONE.

Decomposition:
- Shared package/include spi_defs: state encoding (IDLE, SETUP, SHIFT, HOLD, DONE), FRAME_BITS=ADDR_W+1+DATA_W, RW_READ=1'b1, RW_WRITE=1'b0.
- Sub-module spi_sclk_gen: CLK_DIV counter with enable/clear, tick output and half-period index (0..31). The FSM, shift registers and output regs stay in spi_master_seq.

Test Plan:
- Write, CLK_DIV=4: addr 0x15, wdata 0x2A → mosi bits sampled on 16 sclk rises = 0010101_0_00101010; cs_n low from T+1; rsp_valid at T+137 with rsp_rdata=0x00.
- Read with a behavioural slave returning 0xC3 on miso for data bits, addr 0x40 → mosi = 1000000_1_00000000; rsp_rdata=0xC3 with rsp_valid; exactly 16 sclk rises.
- req_valid held high through a frame with changing req_addr → only one frame is sent, using the addr sampled at accept. The second request is accepted in the IDLE cycle after DONE, giving cs_n high for 2 clk.
- Reset asserted asynchronously after 5 sclk rises → cs_n=1 and sclk=0 with no clk edge; no rsp_valid. After release, req_ready=1 and a new write completes normally.
- CLK_DIV=2 read of 0xFF, then a write → sclk period 4 clk; rsp_valid at T+69; busy falls after rsp_valid.
